serial_4bit_subtractor: RTL

Bit-serial A − B − Bin subtractor: the inverse-direction companion of the 4-bit ripple-carry full adder. It reuses a single one-bit full adder over WIDTH clock cycles, LSB first, computing A + ~B + ~Bin. Operands arrive and results leave through valid/ready handshakes, so it can sit behind a stimulus source and in front of a checker. It is also the reference subtractor for cross-checking the adder: for any operands, (A − B) + B must reproduce A.

---
 rtl/sub_pkg.sv | 14 +
 rtl/full_adder_1bit.sv | 15 +
 rtl/serial_4bit_subtractor.sv | 113 +++++++++++
 3 files changed

// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   DEFAULT_WIDTH : default operand/result width
//   sub_state_t   : controller states (IDLE accepts, CALC shifts, DONE presents result)
package sub_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } sub_state_t;

endpackage

// File: rtl/full_adder_1bit.sv
// One-bit combinational full adder.
//   a, b, cin : addend bits and carry in
//   s, cout   : sum bit and carry out
module full_adder_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_4bit_subtractor.sv
// Bit-serial A - B - Bin subtractor. One full adder evaluates A + ~B + ~Bin LSB first,
// one bit per clock, so a result takes WIDTH cycles after acceptance.
//   clk, reset_n          : rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   : operand handshake (A, B, Bin); ready only while idle
//   out_valid / out_ready : result handshake (D, Bout); result held until accepted
//   D                     : A - B - Bin mod 2^WIDTH
//   Bout                  : borrow out, 1 when A < B + Bin
//   busy                  : operation in flight or result pending
module serial_4bit_subtractor
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  sub_state_t      state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] d_sr_q, d_sr_d;
  logic             carry_q, carry_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic fa_s;
  logic fa_cout;

  full_adder_1bit u_fa (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    d_sr_d  = d_sr_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Subtraction as A + ~B + ~Bin: invert subtrahend and borrow on entry.
          a_sr_d  = A;
          b_sr_d  = ~B;
          carry_d = ~Bin;
          cnt_d   = '0;
          d_sr_d  = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        a_sr_d  = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d  = {1'b0, b_sr_q[WIDTH-1:1]};
        d_sr_d  = {fa_s, d_sr_q[WIDTH-1:1]};
        carry_d = fa_cout;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      d_sr_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      d_sr_q  <= d_sr_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode registered state only; result is masked outside DONE so a
  // partially shifted difference or the inverted carry never leaks out.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == CALC) || (state_q == DONE);
  assign D         = out_valid ? d_sr_q : '0;
  assign Bout      = out_valid & ~carry_q;

endmodule
